// File: rtl/gol_step_engine_if.sv
// Step handshake and pattern-load bus between a controller (master) and the
// Game-of-Life step engine (slave).
interface gol_step_engine_if #(
    parameter int FIELD_W = 8,
    parameter int FIELD_H = 8,
    parameter int GEN_W   = 16
);
    localparam int N_CELLS = FIELD_W * FIELD_H;

    logic               i_go;
    logic               o_NFI_allowed;
    logic               i_load_en;
    logic [N_CELLS-1:0] i_load_data;
    logic [N_CELLS-1:0] o_field;
    logic [GEN_W-1:0]   o_gen_cnt;

    modport master (
        output i_go, i_load_en, i_load_data,
        input  o_NFI_allowed, o_field, o_gen_cnt
    );

    modport slave (
        input  i_go, i_load_en, i_load_data,
        output o_NFI_allowed, o_field, o_gen_cnt
    );
endinterface

// File: rtl/gol_step_engine.sv
// Toroidal B3/S23 Game-of-Life engine: evaluates one cell per clock into a
// shadow buffer, then commits the whole next generation in a single cycle.
module gol_step_engine #(
    parameter int FIELD_W = 8,
    parameter int FIELD_H = 8,
    parameter int GEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    gol_step_engine_if.slave bus
);
    localparam int N_CELLS = FIELD_W * FIELD_H;
    localparam int IDX_W   = $clog2(N_CELLS);
    localparam int XW      = $clog2(FIELD_W);
    localparam int YW      = $clog2(FIELD_H);

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    state_t             r_state;
    logic [N_CELLS-1:0] r_field;
    logic [N_CELLS-1:0] r_next;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic [GEN_W-1:0]   r_gen;
    logic               r_allowed;

    logic [XW-1:0]      w_xm, w_xp;
    logic [YW-1:0]      w_ym, w_yp;
    logic [7:0]         w_nb;
    logic [3:0]         w_cnt;
    logic               w_alive;
    logic               w_new;
    logic               w_last;

    function automatic logic [IDX_W-1:0] cidx(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return IDX_W'(y) * IDX_W'(FIELD_W) + IDX_W'(x);
    endfunction

    // Torus neighbours: edges wrap to the opposite side.
    assign w_xm = (r_x == '0) ? XW'(FIELD_W - 1) : r_x - 1'b1;
    assign w_xp = (r_x == XW'(FIELD_W - 1)) ? '0 : r_x + 1'b1;
    assign w_ym = (r_y == '0) ? YW'(FIELD_H - 1) : r_y - 1'b1;
    assign w_yp = (r_y == YW'(FIELD_H - 1)) ? '0 : r_y + 1'b1;
    assign w_last = (r_x == XW'(FIELD_W - 1)) && (r_y == YW'(FIELD_H - 1));

    always_comb begin
        w_nb[0] = r_field[cidx(w_xm, w_ym)];
        w_nb[1] = r_field[cidx(r_x,  w_ym)];
        w_nb[2] = r_field[cidx(w_xp, w_ym)];
        w_nb[3] = r_field[cidx(w_xm, r_y )];
        w_nb[4] = r_field[cidx(w_xp, r_y )];
        w_nb[5] = r_field[cidx(w_xm, w_yp)];
        w_nb[6] = r_field[cidx(r_x,  w_yp)];
        w_nb[7] = r_field[cidx(w_xp, w_yp)];
        w_cnt   = '0;
        for (int i = 0; i < 8; i++) w_cnt = w_cnt + {3'b000, w_nb[i]};
        w_alive = r_field[cidx(r_x, r_y)];
        w_new   = (w_cnt == 4'd3) | (w_alive & (w_cnt == 4'd2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_field   <= '0;
            r_next    <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_gen     <= '0;
            r_allowed <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    // Load has priority; a coincident go is dropped.
                    if (bus.i_load_en) begin
                        r_field <= bus.i_load_data;
                        r_gen   <= '0;
                    end else if (bus.i_go) begin
                        r_x       <= '0;
                        r_y       <= '0;
                        r_state   <= CALC;
                        r_allowed <= 1'b0;
                    end
                end
                CALC: begin
                    r_next[cidx(r_x, r_y)] <= w_new;
                    if (w_last) begin
                        r_state <= COMMIT;
                    end else if (r_x == XW'(FIELD_W - 1)) begin
                        r_x <= '0;
                        r_y <= r_y + 1'b1;
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
                COMMIT: begin
                    r_field   <= r_next;
                    r_gen     <= r_gen + 1'b1;
                    r_state   <= IDLE;
                    r_allowed <= 1'b1;
                end
                default: begin
                    r_state   <= IDLE;
                    r_allowed <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_NFI_allowed = r_allowed;
    assign bus.o_field       = r_field;
    assign bus.o_gen_cnt     = r_gen;
endmodule
